// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// and a line-wide memory. Hits cost no cycles; misses stall for WB and/or FILL.
module dcache_ctrl #(
  parameter int LINES = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  input  logic         cpu_memread_i,
  input  logic         cpu_memwrite_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic [127:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [127:0]     data_q [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag_in;
  logic [1:0]       off;
  logic [127:0]     line;
  logic [31:0]      word;
  logic             access;
  logic             hit;
  logic             fill_done;
  logic             store_hit;
  logic             unused_addr;

  assign idx         = cpu_addr_i[4+IDX_W-1:4];
  assign tag_in      = cpu_addr_i[31:4+IDX_W];
  assign off         = cpu_addr_i[3:2];
  assign unused_addr = ^cpu_addr_i[1:0];

  assign line      = data_q[idx];
  assign word      = line[{off, 5'b0} +: 32];
  assign access    = cpu_memread_i | cpu_memwrite_i;
  assign hit       = access & valid_q[idx] & (tag_q[idx] == tag_in);
  assign fill_done = (state_q == S_FILL) & mem_ack_i;
  assign store_hit = (state_q == S_IDLE) & hit & cpu_memwrite_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (access && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_FILL;
        end
      end
      S_WB:   if (mem_ack_i) state_d = S_FILL;
      S_FILL: if (mem_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (fill_done) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
    if (store_hit) begin
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (fill_done) begin
      tag_q[idx]  <= tag_in;
      data_q[idx] <= mem_rdata_i;
    end else if (store_hit) begin
      data_q[idx][{off, 5'b0} +: 32] <= cpu_wdata_i;
    end
  end

  // All outputs are forced low while reset is held, independent of the clock.
  always_comb begin
    cpu_rdata_o = '0;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (rst_i) begin
      unique case (state_q)
        S_IDLE: begin
          cpu_stall_o = access & ~hit;
          if (hit && cpu_memread_i && !cpu_memwrite_i) begin
            cpu_rdata_o = word;
          end
        end
        S_WB: begin
          cpu_stall_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {tag_q[idx], idx, 4'b0};
          mem_wdata_o = line;
        end
        S_FILL: begin
          cpu_stall_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_addr_o  = {tag_in, idx, 4'b0};
        end
        default: begin
          cpu_stall_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: stimulus queues expected CPU completions
// and memory transactions; a monitor checks them as the DUT presents them.
module tb_dcache_ctrl;

  typedef struct packed {
    logic [31:0] rdata;
    logic [7:0]  stalls;
  } cpu_exp_t;

  typedef struct packed {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mem_exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  addr = '0;
  logic [31:0]  wdata = '0;
  logic         rd = 1'b0;
  logic         wr = 1'b0;
  logic [31:0]  rdata;
  logic         stall;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ack;
  logic         resp_ack = 1'b0;
  logic         spur_ack = 1'b0;
  logic [127:0] mem_line = '0;
  logic         done = 1'b0;

  cpu_exp_t exp_cpu[$];
  mem_exp_t exp_mem[$];
  int       dly_q[$];

  int checks = 0;
  int errors = 0;

  assign mem_ack = resp_ack | spur_ack;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(32)) dut (
    .clk_i          (clk),
    .rst_i          (rst_n),
    .cpu_addr_i     (addr),
    .cpu_wdata_i    (wdata),
    .cpu_memread_i  (rd),
    .cpu_memwrite_i (wr),
    .cpu_rdata_o    (rdata),
    .cpu_stall_o    (stall),
    .mem_req_o      (mem_req),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata),
    .mem_ack_i      (mem_ack)
  );

  // Memory responder: acks each transaction after the queued cycle count.
  initial begin
    int cnt;
    int dly;
    cnt = 0;
    dly = 1000;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
        resp_ack = 1'b0;
      end else if (mem_req) begin
        cnt++;
        if (cnt == 1) dly = (dly_q.size() > 0) ? dly_q.pop_front() : 1000;
        #1;
        if (cnt == dly) begin
          resp_ack  = 1'b1;
          mem_rdata = mem_line;
          cnt       = 0;
        end else begin
          resp_ack = 1'b0;
        end
      end else begin
        #1 resp_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Monitor: samples on negedge and reacts to asynchronous reset edges.
  initial begin
    logic     rst_prev;
    logic     prev_req;
    logic     new_txn;
    int       stall_cnt;
    mem_exp_t held;
    mem_exp_t em;
    cpu_exp_t ec;
    rst_prev  = 1'b0;
    prev_req  = 1'b0;
    stall_cnt = 0;
    held      = '0;
    forever begin
      @(negedge clk or rst_n);
      if (rst_n !== rst_prev) begin
        rst_prev = rst_n;
        #1;
        checks++;
        if (!rst_n) begin
          if (mem_req || mem_we || mem_addr != 0 || mem_wdata != 0 || stall || rdata != 0) begin
            errors++;
            $display("FAIL reset_async: req=%b we=%b addr=%h stall=%b rdata=%h, want all zero",
                     mem_req, mem_we, mem_addr, stall, rdata);
          end
          stall_cnt = 0;
          prev_req  = 1'b0;
        end else if (stall !== (rd | wr)) begin
          errors++;
          $display("FAIL release_stall: stall=%b want %b", stall, rd | wr);
        end
      end else if (!clk) begin
        if (done) begin
          checks++;
          if (exp_cpu.size() != 0 || exp_mem.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: cpu=%0d mem=%0d pending, want 0",
                     exp_cpu.size(), exp_mem.size());
          end
          $display("Simulation finished: %0d checks, %0d errors", checks, errors);
          $finish;
        end else if (!rst_n) begin
          checks++;
          if (mem_req || mem_we || mem_addr != 0 || mem_wdata != 0 || stall || rdata != 0) begin
            errors++;
            $display("FAIL reset_hold: req=%b we=%b addr=%h stall=%b rdata=%h, want all zero",
                     mem_req, mem_we, mem_addr, stall, rdata);
          end
        end else begin
          if (mem_req) begin
            new_txn = !prev_req || mem_ack;
            checks++;
            if (new_txn) begin
              held = {mem_we, mem_addr, mem_wdata};
              if (exp_mem.size() == 0) begin
                errors++;
                $display("FAIL mem_txn: unexpected we=%b addr=%h", mem_we, mem_addr);
              end else begin
                em = exp_mem.pop_front();
                if (mem_we !== em.we || mem_addr !== em.addr || mem_wdata !== em.wdata) begin
                  errors++;
                  $display("FAIL mem_txn: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                           mem_we, mem_addr, mem_wdata, em.we, em.addr, em.wdata);
                end
              end
            end else if ({mem_we, mem_addr, mem_wdata} !== held) begin
              errors++;
              $display("FAIL mem_stable: got we=%b addr=%h, want we=%b addr=%h",
                       mem_we, mem_addr, held.we, held.addr);
            end
          end
          prev_req = mem_req;
          if (rd || wr) begin
            if (stall) begin
              stall_cnt++;
            end else begin
              checks++;
              if (exp_cpu.size() == 0) begin
                errors++;
                $display("FAIL cpu_resp: unexpected completion addr=%h", addr);
              end else begin
                ec = exp_cpu.pop_front();
                if (rdata !== ec.rdata || stall_cnt != int'(ec.stalls)) begin
                  errors++;
                  $display("FAIL cpu_resp addr=%h: got rdata=%h stalls=%0d, want rdata=%h stalls=%0d",
                           addr, rdata, stall_cnt, ec.rdata, ec.stalls);
                end
              end
              stall_cnt = 0;
            end
          end else begin
            checks++;
            if (mem_req || stall || rdata != 0) begin
              errors++;
              $display("FAIL idle_outputs: req=%b stall=%b rdata=%h, want 0 0 0",
                       mem_req, stall, rdata);
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic r,
                       input logic w, input logic [31:0] er, input int es);
    exp_cpu.push_back({er, 8'(es)});
    addr  = a;
    wdata = wd;
    rd    = r;
    wr    = w;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (!stall) break;
      n++;
      if (n > 60) begin
        $display("FAIL stall_timeout: stall still high after %0d cycles", n);
        $fatal(1, "stall timeout");
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    rd = 1'b0;
    wr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Load held through reset; it must miss right after release.
    addr = 32'h0000_0104;
    rd   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_mem.push_back({1'b0, 32'h0000_0100, 128'h0});
    dly_q.push_back(3);
    mem_line = {32'h44, 32'h33, 32'h22, 32'h11};
    exp_cpu.push_back({32'h22, 8'd4});
    rst_n = 1'b1;
    wait_done();

    issue(32'h0000_0108, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 0);
    wait_done();
    issue(32'h0000_0108, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 0);
    wait_done();

    // Spurious acks in IDLE, first idle then during a hit.
    mem_line = {4{32'hFFFF_FFFF}};
    rd = 1'b0;
    wr = 1'b0;
    spur_ack = 1'b1;
    @(posedge clk);
    #1 spur_ack = 1'b0;
    idle_cycles(1);
    issue(32'h0000_0104, 32'h0, 1'b1, 1'b0, 32'h22, 0);
    spur_ack = 1'b1;
    wait_done();
    spur_ack = 1'b0;
    issue(32'h0000_0100, 32'h0, 1'b1, 1'b0, 32'h11, 0);
    wait_done();
    issue(32'h0000_010C, 32'h0, 1'b1, 1'b0, 32'h44, 0);
    wait_done();

    // Dirty eviction: WB of the tag-0 line, then FILL of tag 1.
    exp_mem.push_back({1'b1, 32'h0000_0100, {32'h44, 32'hDEAD_BEEF, 32'h22, 32'h11}});
    exp_mem.push_back({1'b0, 32'h0000_0300, 128'h0});
    dly_q.push_back(2);
    dly_q.push_back(3);
    mem_line = {32'h88, 32'h77, 32'h66, 32'h55};
    issue(32'h0000_0304, 32'h0, 1'b1, 1'b0, 32'h66, 6);
    wait_done();

    // Clean victim, ack in the first FILL cycle.
    exp_mem.push_back({1'b0, 32'h0000_0100, 128'h0});
    dly_q.push_back(1);
    mem_line = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    issue(32'h0000_0104, 32'h0, 1'b1, 1'b0, 32'hA2, 2);
    wait_done();

    // Store miss allocates, then completes through the hit path.
    exp_mem.push_back({1'b0, 32'h0000_0000, 128'h0});
    dly_q.push_back(2);
    mem_line = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
    issue(32'h0000_000C, 32'h1234_5678, 1'b0, 1'b1, 32'h0, 3);
    wait_done();
    issue(32'h0000_000C, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 0);
    wait_done();
    issue(32'h0000_0000, 32'h0, 1'b1, 1'b0, 32'hB1, 0);
    wait_done();

    // Reset in the middle of a FILL that memory never acks.
    exp_mem.push_back({1'b0, 32'h0000_0500, 128'h0});
    addr = 32'h0000_0504;
    rd   = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (mem_req) break;
      if (i == 10) begin
        $display("FAIL fill_start_timeout: mem_req never rose");
        $fatal(1, "fill start timeout");
      end
    end
    @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_mem.push_back({1'b0, 32'h0000_0500, 128'h0});
    dly_q.push_back(2);
    mem_line = {32'hC4, 32'hC3, 32'hC2, 32'hC1};
    exp_cpu.push_back({32'hC2, 8'd3});
    rst_n = 1'b1;
    wait_done();

    // Dirty bit of index 0 was cleared by reset: plain FILL, no WB.
    exp_mem.push_back({1'b0, 32'h0000_0000, 128'h0});
    dly_q.push_back(2);
    mem_line = {32'hD4, 32'hD3, 32'hD2, 32'hD1};
    issue(32'h0000_000C, 32'h0, 1'b1, 1'b0, 32'hD4, 3);
    wait_done();

    idle_cycles(2);
    done = 1'b1;
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and the line-wide data memory. It serves MEM-stage loads and stores in zero added cycles on a hit. On a miss it stalls the pipeline while it writes back a dirty victim line and refills the requested line over a req/ack memory handshake.

## Interface
Parameters:
- LINES, 32, number of cache lines; power of two, at least 2. IDX_W = log2(LINES).
- Line size is fixed at 4 words (128 bits). Address fields: offset = addr[3:2], index = addr[3+IDX_W:4], tag = addr[31:4+IDX_W].

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- cpu_addr_i  in  32  byte address from EX/MEM; addr[1:0] ignored.
- cpu_wdata_i  in  32  store data.
- cpu_memread_i  in  1  load request.
- cpu_memwrite_i  in  1  store request.
- cpu_rdata_o  out  32  load data; valid when a load hits.
- cpu_stall_o  out  1  freeze PC and all pipeline registers.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = line write-back, 0 = line fill.
- mem_addr_o  out  32  line-aligned address; [3:0] = 0.
- mem_wdata_o  out  128  victim line; word 0 in bits [31:0].
- mem_rdata_i  in  128  fill line, same word order.
- mem_ack_i  in  1  one-cycle completion pulse.

## Operation
- Per line storage: valid, dirty, tag, and 128-bit data. Tag/valid/dirty are held in flops so the lookup is combinational.
- Access: access = cpu_memread_i | cpu_memwrite_i. hit = access & valid[idx] & (tag[idx] == addr tag). When both request inputs are high, the access is a store.
- FSM states:
  - IDLE: no memory request.
  - WB: write back the victim.
  - FILL: refill the requested line.
- IDLE behaviour:
  - Load hit: cpu_rdata_o = data word at offset, combinationally; cpu_stall_o = 0.
  - Store hit: the word at offset takes cpu_wdata_i and dirty is set at the clock edge; cpu_stall_o = 0.
  - Miss: cpu_stall_o = 1 combinationally. Next state is WB if the victim is valid & dirty, otherwise FILL.
  - No access: stall 0; cpu_rdata_o = 0.
- WB: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, idx, 4'b0}, mem_wdata_o = victim data. On mem_ack_i, go to FILL.
- FILL: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {cpu tag, idx, 4'b0}, mem_wdata_o = 0. On mem_ack_i, load mem_rdata_i into the line, set valid = 1, write the tag, clear dirty, and go to IDLE.
- After FILL the access is re-evaluated in IDLE, hits, and stall drops. A store completes through that normal hit path, which sets dirty.
- cpu_stall_o = 1 throughout WB and FILL.
- CPU contract: cpu_addr_i, cpu_wdata_i and the request inputs are held stable while cpu_stall_o = 1.
- mem_ack_i is ignored in IDLE.
- Memory contract: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay constant from the first cycle of a state until the ack.

## Timing
- Reset, asynchronous, while rst_i = 0:
  - State returns to IDLE; all valid and dirty bits clear.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - cpu_rdata_o = 0, cpu_stall_o = 0.
  - Tag and data arrays are not reset.
- Reset mid-WB or mid-FILL: mem_req_o falls immediately. The partial transaction is abandoned; memory must discard it.
- Hit latency: 0 extra cycles.
- Clean miss, ack N cycles after entering FILL (N ≥ 1): 1 IDLE detect cycle, N FILL cycles, then 1 IDLE hit cycle. cpu_stall_o is high for N+1 cycles.
- Dirty miss: adds the WB cycles before FILL.
- mem_req_o, mem_we_o and mem_addr_o are Moore outputs decoded from the state register and its held inputs. They are glitch-free relative to mem_ack_i.
- An ack arriving in the first cycle of WB or FILL is legal. The state advances at that edge.

## Test plan
- Reset:
  - Stimulus: rst_i = 0 for 2 cycles, then release; load from 0x0000_0104.
  - Required: cpu_stall_o = 1 immediately; FILL presents mem_addr_o = 0x0000_0100 with mem_we_o = 0.
- Clean load miss:
  - Stimulus: ack after 3 cycles with mem_rdata_i = {0x44, 0x33, 0x22, 0x11}.
  - Required: stall high for 4 cycles, then cpu_rdata_o = 0x22 with stall 0.
- Store hit then read-back:
  - Stimulus: store 0xDEAD_BEEF to 0x0000_0108, then load 0x0000_0108.
  - Required: no stall on either access; load returns 0xDEAD_BEEF.
- Dirty eviction:
  - Stimulus: after the store above, load 0x0000_0304 (same index 0x10, tag 1).
  - Required first transaction: mem_we_o = 1, mem_addr_o = 0x0000_0100, mem_wdata_o[95:64] = 0xDEAD_BEEF.
  - Required second transaction: FILL at 0x0000_0300.
- Spurious ack:
  - Stimulus: pulse mem_ack_i in IDLE, with and without a hit.
  - Required: no state change, no array update, mem_req_o stays 0.
- Reset mid-FILL:
  - Stimulus: drop rst_i while mem_req_o = 1, then reload the same address.
  - Required: mem_req_o = 0 with no clock edge needed; the reload misses again because valid was cleared.
